// File: rtl/writeback_queue.sv
// writeback_queue: in-order writeback buffer in front of the 32x32 register file write port.
// Accepts results from the ALU and the load unit (valid/ready each), queues them in a
// DEPTH-entry FIFO, and drains one entry per cycle into a registered write stage.
// Results destined for R0 are accepted and discarded.
//
// Optional feature macro: WRITEBACK_BYPASS_EN
//   defined   - byp_* ports return the youngest pending data for the looked-up register
//   undefined - byp_hit_* and byp_data_* are tied to zero (ports kept for interface stability)
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   alu_valid/ready/rd/data           ALU result handshake
//   ld_valid/ready/rd/data            load result handshake
//   rf_write_en/rf_addr_w/rf_data_w   registered register file write port
//   byp_addr_a/b, byp_hit_a/b,
//   byp_data_a/b                      combinational bypass lookup of pending writes
//   count                             FIFO occupancy (output stage excluded)
//   empty                             nothing queued and no write being issued
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [4:0]                   alu_rd,
  input  logic [31:0]                  alu_data,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [4:0]                   ld_rd,
  input  logic [31:0]                  ld_data,
  output logic                         rf_write_en,
  output logic [4:0]                   rf_addr_w,
  output logic [31:0]                  rf_data_w,
  input  logic [4:0]                   byp_addr_a,
  output logic                         byp_hit_a,
  output logic [31:0]                  byp_data_a,
  input  logic [4:0]                   byp_addr_b,
  output logic                         byp_hit_b,
  output logic [31:0]                  byp_data_b,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [4:0]      rd_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d, free;
  logic            out_en_q;
  logic [4:0]      out_addr_q;
  logic [31:0]     out_data_q;

  logic            alu_push, ld_push, pop;
  logic [PtrW-1:0] ld_wr_idx;

  // Readiness depends on registered occupancy only; a same-cycle pop gives no credit.
  always_comb begin
    free      = CntW'(DEPTH) - count_q;
    alu_ready = free >= CntW'(1);
    ld_ready  = (free >= CntW'(2)) || ((free >= CntW'(1)) && !alu_valid);
  end

  // R0 results complete the handshake but never occupy an entry.
  always_comb begin
    alu_push  = alu_valid && alu_ready && (alu_rd != 5'd0);
    ld_push   = ld_valid && ld_ready && (ld_rd != 5'd0);
    pop       = count_q != '0;
    ld_wr_idx = wr_ptr_q + PtrW'(alu_push);
    count_d   = count_q + CntW'(alu_push) + CntW'(ld_push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_en_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(alu_push) + PtrW'(ld_push);
      count_q  <= count_d;
      if (pop) begin
        out_en_q   <= 1'b1;
        out_addr_q <= rd_mem[rd_ptr_q];
        out_data_q <= data_mem[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
      end else begin
        out_en_q <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset: count gates visibility of every slot.
  // ALU lands first so it is the older of two same-cycle entries.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      rd_mem[wr_ptr_q]   <= alu_rd;
      data_mem[wr_ptr_q] <= alu_data;
    end
    if (ld_push) begin
      rd_mem[ld_wr_idx]   <= ld_rd;
      data_mem[ld_wr_idx] <= ld_data;
    end
  end

  assign rf_write_en = out_en_q;
  assign rf_addr_w   = out_addr_q;
  assign rf_data_w   = out_data_q;
  assign count       = count_q;
  assign empty       = (count_q == '0) && !out_en_q;

`ifdef WRITEBACK_BYPASS_EN
  // Scan oldest to youngest so later matches override; output stage is the oldest source.
  function automatic logic [32:0] lookup(input logic [4:0] addr);
    logic            hit;
    logic [31:0]     data;
    logic [PtrW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    if (out_en_q && (out_addr_q == addr)) begin
      hit  = 1'b1;
      data = out_data_q;
    end
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = rd_ptr_q + PtrW'(k);
      if ((k < int'(count_q)) && (rd_mem[idx] == addr)) begin
        hit  = 1'b1;
        data = data_mem[idx];
      end
    end
    if (addr == 5'd0) begin
      hit  = 1'b0;
      data = '0;
    end
    return {hit, data};
  endfunction

  always_comb begin
    {byp_hit_a, byp_data_a} = lookup(byp_addr_a);
    {byp_hit_b, byp_data_b} = lookup(byp_addr_b);
  end
`else
  always_comb begin
    byp_hit_a  = 1'b0;
    byp_data_a = '0;
    byp_hit_b  = 1'b0;
    byp_data_b = '0;
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int VW    = 107 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, ld_valid;
  logic          alu_ready, ld_ready;
  logic [4:0]    alu_rd, ld_rd;
  logic [31:0]   alu_data, ld_data;
  logic          rf_write_en;
  logic [4:0]    rf_addr_w;
  logic [31:0]   rf_data_w;
  logic [4:0]    byp_addr_a, byp_addr_b;
  logic          byp_hit_a, byp_hit_b;
  logic [31:0]   byp_data_a, byp_data_b;
  logic [CW-1:0] count;
  logic          empty;

  int vectors = 0;
  int miscompares = 0;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .rf_write_en(rf_write_en),
    .rf_addr_w  (rf_addr_w),
    .rf_data_w  (rf_data_w),
    .byp_addr_a (byp_addr_a),
    .byp_hit_a  (byp_hit_a),
    .byp_data_a (byp_data_a),
    .byp_addr_b (byp_addr_b),
    .byp_hit_b  (byp_hit_b),
    .byp_data_b (byp_data_b),
    .count      (count),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes as a plain queue (front = oldest) plus the issued write.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_en = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  function automatic logic [32:0] m_byp(input logic [4:0] a);
`ifdef WRITEBACK_BYPASS_EN
    if (a == 5'd0) return 33'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rd == a) return {1'b1, mq[i].data};
    if (m_en && m_addr == a) return {1'b1, m_data};
`endif
    return 33'd0 | {28'd0, a} & 33'd0;
  endfunction

  function automatic logic m_alu_ready();
    return (DEPTH - mq.size()) >= 1;
  endfunction

  function automatic logic m_ld_ready();
    int f;
    f = DEPTH - mq.size();
    return (f >= 2) || (f >= 1 && !alu_valid);
  endfunction

  function automatic logic [VW-1:0] m_expect();
    return {m_alu_ready(), m_ld_ready(), m_en, m_addr, m_data, m_byp(byp_addr_a),
            m_byp(byp_addr_b), CW'(mq.size()), (mq.size() == 0) && !m_en};
  endfunction

  function automatic logic [VW-1:0] dut_obs();
    return {alu_ready, ld_ready, rf_write_en, rf_addr_w, rf_data_w, byp_hit_a, byp_data_a,
            byp_hit_b, byp_data_b, count, empty};
  endfunction

  // Advance one clock (called at a negedge, returns at the next negedge), updating the model.
  task automatic cycle();
    logic ar, lr;
    ent_t e;
    ar = m_alu_ready();
    lr = m_ld_ready();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_en = 1'b1; m_addr = e.rd; m_data = e.data;
      end else begin
        m_en = 1'b0;
      end
      if (alu_valid && ar && alu_rd != 5'd0) mq.push_back({alu_rd, alu_data});
      if (ld_valid && lr && ld_rd != 5'd0) mq.push_back({ld_rd, ld_data});
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; ld_valid = 0;
    alu_rd = '0; ld_rd = '0; alu_data = '0; ld_data = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    byp_addr_a = '0; byp_addr_b = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;
    #1;
    vectors++;
    if ({rf_write_en, count, empty, alu_ready, ld_ready} !== {1'b0, CW'(0), 3'b111}) begin
      miscompares++;
      $display("FAIL reset_state: got en=%0b cnt=%0d empty=%0b ar=%0b lr=%0b want 0 0 1 1 1",
               rf_write_en, count, empty, alu_ready, ld_ready);
    end
    vectors++;
    if ({rf_addr_w, rf_data_w} !== 37'd0) begin
      miscompares++;
      $display("FAIL reset_rf: got addr=%0d data=%h want 0 0", rf_addr_w, rf_data_w);
    end
    cycle();
  endtask

  task automatic test_single_alu();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    vectors++;
    if ({rf_write_en, count} !== {1'b0, CW'(1)}) begin
      miscompares++;
      $display("FAIL single_queued: got en=%0b cnt=%0d want 0 1", rf_write_en, count);
    end
    cycle();
    vectors++;
    if ({rf_write_en, rf_addr_w, rf_data_w} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL single_write: got en=%0b addr=%0d data=%h want 1 5 deadbeef",
               rf_write_en, rf_addr_w, rf_data_w);
    end
    cycle();
    vectors++;
    if ({rf_write_en, empty} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_done: got en=%0b empty=%0b want 0 1", rf_write_en, empty);
    end
  endtask

  task automatic test_dual_same_rd();
    logic [32:0] exp_byp;
`ifdef WRITEBACK_BYPASS_EN
    exp_byp = {1'b1, 32'h22};
`else
    exp_byp = 33'd0;
`endif
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
    ld_valid = 1;  ld_rd = 5'd3;  ld_data = 32'h22;
    byp_addr_a = 5'd3;
    #1;
    vectors++;
    if ({alu_ready, ld_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL dual_ready: got ar=%0b lr=%0b want 1 1", alu_ready, ld_ready);
    end
    cycle();
    idle_inputs();
    #1;
    vectors++;
    if ({count, rf_write_en, byp_hit_a, byp_data_a} !== {CW'(2), 1'b0, exp_byp}) begin
      miscompares++;
      $display("FAIL dual_pending: got cnt=%0d en=%0b hit=%0b data=%h want 2 0 %0b %h",
               count, rf_write_en, byp_hit_a, byp_data_a, exp_byp[32], exp_byp[31:0]);
    end
    cycle();
    vectors++;
    if ({rf_write_en, rf_addr_w, rf_data_w, byp_hit_a, byp_data_a}
        !== {1'b1, 5'd3, 32'h11, exp_byp}) begin
      miscompares++;
      $display("FAIL dual_first: got en=%0b addr=%0d data=%h hit=%0b bd=%h", rf_write_en,
               rf_addr_w, rf_data_w, byp_hit_a, byp_data_a);
    end
    cycle();
    vectors++;
    if ({rf_write_en, rf_addr_w, rf_data_w, byp_hit_a, byp_data_a}
        !== {1'b1, 5'd3, 32'h22, exp_byp}) begin
      miscompares++;
      $display("FAIL dual_second: got en=%0b addr=%0d data=%h hit=%0b bd=%h", rf_write_en,
               rf_addr_w, rf_data_w, byp_hit_a, byp_data_a);
    end
    cycle();
    vectors++;
    if ({rf_write_en, byp_hit_a, byp_data_a} !== 34'd0) begin
      miscompares++;
      $display("FAIL dual_drained: got en=%0b hit=%0b bd=%h want 0 0 0", rf_write_en,
               byp_hit_a, byp_data_a);
    end
  endtask

  // Push both ports every cycle while ready; all 20 results must emerge in order.
  task automatic test_fill_wrap();
    int n = 0;
    int w = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      alu_valid = (n < 20); alu_rd = 5'((n % 31) + 1); alu_data = 32'hA000_0000 + n;
      ld_valid = (n + 1 < 20); ld_rd = 5'(((n + 1) % 31) + 1); ld_data = 32'hA000_0001 + n;
      #1;
      vectors++;
      if (dut_obs() !== m_expect()) begin
        miscompares++;
        $display("FAIL fill_state c%0d: got %h want %h", cyc, dut_obs(), m_expect());
      end
      if (mq.size() >= 3 && alu_valid) begin
        vectors++;
        if (ld_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_ld_ready c%0d: got %0b want 0", cyc, ld_ready);
        end
      end
      if (rf_write_en === 1'b1) begin
        vectors++;
        if (rf_data_w !== 32'hA000_0000 + w) begin
          miscompares++;
          $display("FAIL fill_order w%0d: got %h want %h", w, rf_data_w, 32'hA000_0000 + w);
        end
        w++;
      end
      if (alu_valid && m_alu_ready()) n += (ld_valid && m_ld_ready()) ? 2 : 1;
      else if (ld_valid && m_ld_ready()) n += 1;
      cycle();
    end
    idle_inputs();
    vectors++;
    if (w !== 20) begin
      miscompares++;
      $display("FAIL fill_total: got %0d writes want 20", w);
    end
  endtask

  task automatic test_r0_drop();
    byp_addr_a = 5'd0;
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    vectors++;
    if ({alu_ready, byp_hit_a, byp_data_a} !== {1'b1, 33'd0}) begin
      miscompares++;
      $display("FAIL r0_accept: got ar=%0b hit=%0b bd=%h want 1 0 0", alu_ready, byp_hit_a,
               byp_data_a);
    end
    cycle();
    idle_inputs();
    vectors++;
    if ({count, rf_write_en} !== {CW'(0), 1'b0}) begin
      miscompares++;
      $display("FAIL r0_count: got cnt=%0d en=%0b want 0 0", count, rf_write_en);
    end
    cycle();
    vectors++;
    if ({rf_write_en, empty, byp_hit_a, byp_data_a} !== {2'b01, 33'd0}) begin
      miscompares++;
      $display("FAIL r0_nowrite: got en=%0b empty=%0b hit=%0b bd=%h", rf_write_en, empty,
               byp_hit_a, byp_data_a);
    end
  endtask

  task automatic test_reset_pending();
    int seen = 0;
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'hC0DE_0000 + i;
      ld_valid = 1;  ld_rd = 5'(20 + i);  ld_data = 32'hBEEF_0000 + i;
      cycle();
    end
    idle_inputs();
    vectors++;
    if (count !== CW'(3)) begin
      miscompares++;
      $display("FAIL rstp_setup: got cnt=%0d want 3", count);
    end
    rst = 1;
    cycle();
    rst = 0;
    vectors++;
    if ({count, rf_write_en, empty} !== {CW'(0), 2'b01}) begin
      miscompares++;
      $display("FAIL rstp_cleared: got cnt=%0d en=%0b empty=%0b want 0 0 1", count,
               rf_write_en, empty);
    end
    for (int i = 0; i < 6; i++) begin
      if (rf_write_en !== 1'b0) seen++;
      cycle();
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL rstp_leak: got %0d writes want 0", seen);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 500; cyc++) begin
      rst = ($urandom_range(0, 63) == 0);
      alu_valid = $urandom_range(0, 3) != 0;
      ld_valid = $urandom_range(0, 2) != 0;
      alu_rd = 5'($urandom_range(0, 7));
      ld_rd = 5'($urandom_range(0, 7));
      alu_data = $urandom;
      ld_data = $urandom;
      byp_addr_a = 5'($urandom_range(0, 7));
      byp_addr_b = 5'($urandom_range(0, 7));
      #1;
      vectors++;
      if (dut_obs() !== m_expect()) begin
        miscompares++;
        $display("FAIL random c%0d: got %h want %h", cyc, dut_obs(), m_expect());
      end
      cycle();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_dual_same_rd();
    test_fill_wrap();
    test_r0_drop();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
